rv_decode_stage: RTL and testbench
==================================

Name: rv_decode_stage

Overview:
- Registered RV32I instruction-decode pipeline stage between fetch and execute.
- Accepts {instruction, PC} over a valid/ready handshake and fully decodes it: opcode class, register fields, sign-extended immediate, ALU op, write-enable, illegal flag and a 5-char ASCII mnemonic for the display path.
- Optional RV32M decode, a selectable skid buffer for full-throughput backpressure, flush support and a saturating illegal-instruction counter.

Parameters:
- XLEN, 32: width of PC and immediate; immediates sign-extend to XLEN.
- SKID, 1: 1 = two-entry skid buffer (in_ready registered, full throughput); 0 = single output register.
- ENABLE_M, 0: 1 = decode RV32M (funct7=0000001 on opcode 0110011); 0 = those encodings are illegal.
- CNT_W, 8: width of the illegal-instruction counter.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  synchronous active-low reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept
- in_instr  in  32  raw instruction
- in_pc  in  XLEN  instruction PC
- flush  in  1  discard all held and incoming instructions
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  downstream accepts
- out_pc  out  XLEN  PC of decoded instruction
- out_rd, out_rs1, out_rs2  out  5 each  instr[11:7], [19:15], [24:20]; forced 0 where the format has no such field
- out_imm  out  XLEN  sign-extended immediate
- out_class  out  7  one-hot {LOAD,R,I,S,B,U,J}; all-zero for NOP/illegal
- out_alu_op  out  4  {alt, funct3}; alt = instr[30] for R-type and SRAI/SRLI, else 0
- out_mul  out  1  RV32M op (only if ENABLE_M)
- out_reg_write  out  1  writes rd (R, I, LOAD, U, J, JALR) and rd != 0
- out_illegal  out  1  unrecognised encoding
- out_mnemonic  out  40  ASCII, space-padded, e.g. "ADDI ", "SLTIU", "NOP  ", "ILL  "
- illegal_count  out  CNT_W  saturating count of illegal instructions accepted

Behaviour:
- Reset (reset_n low at a clock edge): out_valid=0, all bundle fields 0, out_mnemonic="NOP  ", illegal_count=0, buffers emptied. in_ready=0 during reset and 1 on the first cycle after.
- Transfer occurs when valid && ready on the same edge.
- Latency: an accepted instruction appears on out_* on the next cycle.
- Bundle stability: out_* hold stable while out_valid && !out_ready.

Skid buffer:
- SKID=1: main register plus one skid register. in_ready = skid empty.
- Stall with the main register full captures the incoming instruction into skid.
- When out_ready frees main, skid moves to main and in_ready returns next cycle.
- Order is strictly FIFO and no instruction is dropped or duplicated.
- SKID=0: in_ready = !out_valid || out_ready (combinational).

Flush:
- flush=1 clears main and skid at that edge; out_valid=0 next cycle.
- flush suppresses an acceptance on the same edge, and illegal_count does not increment for it.
- flush has priority over everything except reset.

Immediates:
- I/LOAD/JALR: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
- R/NOP/illegal: 0.
- All except U sign-extend from their top bit to XLEN. U sign-extends from bit 31 when XLEN>32.

Illegal detection (out_illegal=1, class 0, reg_write 0, mnemonic "ILL  "):
- Unknown opcode.
- Store funct3 > 2.
- Load funct3 in {3,6,7}.
- Branch funct3 in {2,3}.
- JALR funct3 != 0.
- SLLI funct7 != 0.
- SRLI/SRAI funct7 not in {00,20}.
- R-type funct7 not in {00,20} (or 01 with ENABLE_M=1).
- funct7=20 on R-type with funct3 not 0 or 5.

Other decode rules:
- in_instr == 0: decoded as NOP ("NOP  ", not illegal). 0x00000013 decodes as ADDI.
- illegal_count increments by 1 per accepted illegal instruction and saturates at 2^CNT_W-1.

Test Plan:
- Immediate and field decode, one instruction at a time with out_ready=1:
  - 0xFFF00093 -> out_class I, rd=1, rs1=0, out_imm=0xFFFFFFFF, out_reg_write=1, "ADDI ".
  - 0x0020A423 -> class S, rs1=1, rs2=2, out_imm=8, out_reg_write=0, "SW   ".
  - 0xFE000EE3 -> class B, out_imm=0xFFFFFFFC, "BEQ  ".
  - 0x123452B7 -> class U, rd=5, out_imm=0x12345000, "LUI  ".
- Backpressure, SKID=1: out_ready=0 for 3 cycles while streaming PCs 0x0,0x4,0x8 -> two accepted, in_ready=0 from cycle 2. On release, outputs 0x0 then 0x4 on consecutive cycles, then 0x8; no gaps, loss or reorder.
- Illegal and counter, CNT_W=2: feed 0xFFFFFFFF five times -> out_illegal=1 and "ILL  " each time; illegal_count 1,2,3,3,3.
- RV32M mode: 0x02208033 (mul x0,x1,x2):
  - ENABLE_M=0 -> illegal.
  - ENABLE_M=1 -> out_mul=1, "MUL  ", out_reg_write=0 since rd=0.
- Flush: main and skid full, assert flush with in_valid=1 -> out_valid=0 next cycle, pending instruction not delivered, illegal_count unchanged.
- Reset mid-stall: reset_n=0 with both buffers full -> next cycle out_valid=0, illegal_count=0, "NOP  "; in_ready=1 after reset_n returns high.

Source files
------------

// File: rtl/rv_decode_stage.sv
// RV32I(+M) decode pipeline stage: combinational decode of the incoming
// instruction feeding a main output register and an optional skid register.
module rv_decode_stage #(
  parameter int XLEN     = 32,
  parameter int SKID     = 1,
  parameter int ENABLE_M = 0,
  parameter int CNT_W    = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [XLEN-1:0]  in_pc,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [4:0]       out_rd,
  output logic [4:0]       out_rs1,
  output logic [4:0]       out_rs2,
  output logic [XLEN-1:0]  out_imm,
  output logic [6:0]       out_class,
  output logic [3:0]       out_alu_op,
  output logic             out_mul,
  output logic             out_reg_write,
  output logic             out_illegal,
  output logic [39:0]      out_mnemonic,
  output logic [CNT_W-1:0] illegal_count
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [6:0] C_LOAD = 7'b1000000;
  localparam logic [6:0] C_R    = 7'b0100000;
  localparam logic [6:0] C_I    = 7'b0010000;
  localparam logic [6:0] C_S    = 7'b0001000;
  localparam logic [6:0] C_B    = 7'b0000100;
  localparam logic [6:0] C_U    = 7'b0000010;
  localparam logic [6:0] C_J    = 7'b0000001;

  localparam logic [39:0] NOP_MN = "NOP  ";
  localparam logic [39:0] ILL_MN = "ILL  ";

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [XLEN-1:0] imm;
    logic [6:0]      cls;
    logic [3:0]      alu_op;
    logic            mul;
    logic            reg_write;
    logic            illegal;
    logic [39:0]     mnem;
  } bundle_t;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                   in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                   in_instr[30:21], 1'b0};

  logic        ill, alt, mul, has_alu, use_rd, use_rs1, use_rs2;
  logic [6:0]  cls;
  logic [31:0] imm32;
  logic [39:0] mnem;
  bundle_t     dec;

  always_comb begin
    ill     = 1'b0;
    alt     = 1'b0;
    mul     = 1'b0;
    has_alu = 1'b0;
    use_rd  = 1'b0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    cls     = '0;
    imm32   = '0;
    mnem    = ILL_MN;
    unique case (opcode)
      OP_LOAD: begin
        cls = C_LOAD; use_rd = 1'b1; use_rs1 = 1'b1; imm32 = imm_i; has_alu = 1'b1;
        case (f3)
          3'd0:    mnem = "LB   ";
          3'd1:    mnem = "LH   ";
          3'd2:    mnem = "LW   ";
          3'd4:    mnem = "LBU  ";
          3'd5:    mnem = "LHU  ";
          default: ill = 1'b1;
        endcase
      end
      OP_IMM: begin
        cls = C_I; use_rd = 1'b1; use_rs1 = 1'b1; imm32 = imm_i; has_alu = 1'b1;
        case (f3)
          3'd0: mnem = "ADDI ";
          3'd2: mnem = "SLTI ";
          3'd3: mnem = "SLTIU";
          3'd4: mnem = "XORI ";
          3'd6: mnem = "ORI  ";
          3'd7: mnem = "ANDI ";
          3'd1: begin
            mnem = "SLLI ";
            ill  = (f7 != 7'h00);
          end
          default: begin
            alt = in_instr[30];
            if (f7 == 7'h00)      mnem = "SRLI ";
            else if (f7 == 7'h20) mnem = "SRAI ";
            else                  ill = 1'b1;
          end
        endcase
      end
      OP_STORE: begin
        cls = C_S; use_rs1 = 1'b1; use_rs2 = 1'b1; imm32 = imm_s; has_alu = 1'b1;
        case (f3)
          3'd0:    mnem = "SB   ";
          3'd1:    mnem = "SH   ";
          3'd2:    mnem = "SW   ";
          default: ill = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        cls = C_B; use_rs1 = 1'b1; use_rs2 = 1'b1; imm32 = imm_b; has_alu = 1'b1;
        case (f3)
          3'd0:    mnem = "BEQ  ";
          3'd1:    mnem = "BNE  ";
          3'd4:    mnem = "BLT  ";
          3'd5:    mnem = "BGE  ";
          3'd6:    mnem = "BLTU ";
          3'd7:    mnem = "BGEU ";
          default: ill = 1'b1;
        endcase
      end
      OP_REG: begin
        cls = C_R; use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; has_alu = 1'b1;
        alt = in_instr[30];
        if (f7 == 7'h00) begin
          case (f3)
            3'd0:    mnem = "ADD  ";
            3'd1:    mnem = "SLL  ";
            3'd2:    mnem = "SLT  ";
            3'd3:    mnem = "SLTU ";
            3'd4:    mnem = "XOR  ";
            3'd5:    mnem = "SRL  ";
            3'd6:    mnem = "OR   ";
            default: mnem = "AND  ";
          endcase
        end else if (f7 == 7'h20) begin
          case (f3)
            3'd0:    mnem = "SUB  ";
            3'd5:    mnem = "SRA  ";
            default: ill = 1'b1;
          endcase
        end else if (f7 == 7'h01 && ENABLE_M != 0) begin
          mul = 1'b1;
          // MULHSU is clipped to five characters for the display path
          case (f3)
            3'd0:    mnem = "MUL  ";
            3'd1:    mnem = "MULH ";
            3'd2:    mnem = "MULHS";
            3'd3:    mnem = "MULHU";
            3'd4:    mnem = "DIV  ";
            3'd5:    mnem = "DIVU ";
            3'd6:    mnem = "REM  ";
            default: mnem = "REMU ";
          endcase
        end else begin
          ill = 1'b1;
        end
      end
      OP_LUI: begin
        cls = C_U; use_rd = 1'b1; imm32 = imm_u; mnem = "LUI  ";
      end
      OP_AUIPC: begin
        cls = C_U; use_rd = 1'b1; imm32 = imm_u; mnem = "AUIPC";
      end
      OP_JAL: begin
        cls = C_J; use_rd = 1'b1; imm32 = imm_j; mnem = "JAL  ";
      end
      OP_JALR: begin
        cls = C_I; use_rd = 1'b1; use_rs1 = 1'b1; imm32 = imm_i; has_alu = 1'b1;
        mnem = "JALR ";
        ill  = (f3 != 3'd0);
      end
      default: ill = 1'b1;
    endcase
    // The all-zero word is a bubble, and an illegal encoding carries no fields
    if (in_instr == 32'h0 || ill) begin
      ill     = (in_instr != 32'h0);
      mnem    = ill ? ILL_MN : NOP_MN;
      cls     = '0;
      imm32   = '0;
      alt     = 1'b0;
      mul     = 1'b0;
      has_alu = 1'b0;
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
    end
  end

  always_comb begin
    dec.pc        = in_pc;
    dec.rd        = use_rd  ? in_instr[11:7]  : 5'd0;
    dec.rs1       = use_rs1 ? in_instr[19:15] : 5'd0;
    dec.rs2       = use_rs2 ? in_instr[24:20] : 5'd0;
    dec.imm       = XLEN'(signed'(imm32));
    dec.cls       = cls;
    dec.alu_op    = has_alu ? {alt, f3} : 4'd0;
    dec.mul       = mul;
    dec.reg_write = use_rd && (in_instr[11:7] != 5'd0);
    dec.illegal   = ill;
    dec.mnem      = mnem;
  end

  bundle_t           main_q, main_d, skid_q, skid_d;
  logic              main_valid_q, main_valid_d, skid_valid_q, skid_valid_d;
  logic              rst_done_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              main_free, accept;

  assign main_free = !main_valid_q || out_ready;
  // With the skid buffer the ready only depends on registered state
  assign in_ready  = rst_done_q && ((SKID != 0) ? !skid_valid_q : main_free);
  assign accept    = in_valid && in_ready && !flush;

  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else begin
      if (accept && dec.illegal && cnt_q != {CNT_W{1'b1}})
        cnt_d = cnt_q + CNT_W'(1);
      if (main_free) begin
        if (skid_valid_q) begin
          main_d       = skid_q;
          main_valid_d = 1'b1;
          skid_valid_d = 1'b0;
        end else if (accept) begin
          main_d       = dec;
          main_valid_d = 1'b1;
        end else begin
          main_valid_d = 1'b0;
        end
      end else if (accept) begin
        skid_d       = dec;
        skid_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      main_q       <= '0;
      main_q.mnem  <= NOP_MN;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      rst_done_q   <= 1'b0;
      cnt_q        <= '0;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      rst_done_q   <= 1'b1;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid     = main_valid_q;
  assign out_pc        = main_q.pc;
  assign out_rd        = main_q.rd;
  assign out_rs1       = main_q.rs1;
  assign out_rs2       = main_q.rs2;
  assign out_imm       = main_q.imm;
  assign out_class     = main_q.cls;
  assign out_alu_op    = main_q.alu_op;
  assign out_mul       = main_q.mul;
  assign out_reg_write = main_q.reg_write;
  assign out_illegal   = main_q.illegal;
  assign out_mnemonic  = main_q.mnem;
  assign illegal_count = cnt_q;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Directed bench for rv_decode_stage: A = SKID=1/no M, B = SKID=1/M/CNT_W=2,
// C = SKID=0/no M, all driven from the same stimulus.
module tb_rv_decode_stage;

  logic        clock = 1'b0;
  logic        reset_n, in_valid, flush, out_ready;
  logic [31:0] in_instr, in_pc;

  logic        a_in_ready, a_out_valid, a_mul, a_wr, a_ill;
  logic [31:0] a_pc, a_imm;
  logic [4:0]  a_rd, a_rs1, a_rs2;
  logic [6:0]  a_cls;
  logic [3:0]  a_alu;
  logic [39:0] a_mn;
  logic [7:0]  a_cnt;

  logic        b_in_ready, b_out_valid, b_mul, b_wr, b_ill;
  logic [31:0] b_pc, b_imm;
  logic [4:0]  b_rd, b_rs1, b_rs2;
  logic [6:0]  b_cls;
  logic [3:0]  b_alu;
  logic [39:0] b_mn;
  logic [1:0]  b_cnt;

  logic        c_in_ready, c_out_valid, c_mul, c_wr, c_ill;
  logic [31:0] c_pc, c_imm;
  logic [4:0]  c_rd, c_rs1, c_rs2;
  logic [6:0]  c_cls;
  logic [3:0]  c_alu;
  logic [39:0] c_mn;
  logic [7:0]  c_cnt;

  always #5 clock = ~clock;

  rv_decode_stage #(.XLEN(32), .SKID(1), .ENABLE_M(0), .CNT_W(8)) dut_a (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_pc(a_pc), .out_rd(a_rd), .out_rs1(a_rs1), .out_rs2(a_rs2),
    .out_imm(a_imm), .out_class(a_cls), .out_alu_op(a_alu), .out_mul(a_mul),
    .out_reg_write(a_wr), .out_illegal(a_ill), .out_mnemonic(a_mn), .illegal_count(a_cnt));

  rv_decode_stage #(.XLEN(32), .SKID(1), .ENABLE_M(1), .CNT_W(2)) dut_b (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_pc(b_pc), .out_rd(b_rd), .out_rs1(b_rs1), .out_rs2(b_rs2),
    .out_imm(b_imm), .out_class(b_cls), .out_alu_op(b_alu), .out_mul(b_mul),
    .out_reg_write(b_wr), .out_illegal(b_ill), .out_mnemonic(b_mn), .illegal_count(b_cnt));

  rv_decode_stage #(.XLEN(32), .SKID(0), .ENABLE_M(0), .CNT_W(8)) dut_c (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_pc(c_pc), .out_rd(c_rd), .out_rs1(c_rs1), .out_rs2(c_rs2),
    .out_imm(c_imm), .out_class(c_cls), .out_alu_op(c_alu), .out_mul(c_mul),
    .out_reg_write(c_wr), .out_illegal(c_ill), .out_mnemonic(c_mn), .illegal_count(c_cnt));

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  cls;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic        wr;
    logic        ill;
    logic [39:0] mn;
  } vec_t;

  localparam logic [6:0] K_LOAD = 7'b1000000, K_R = 7'b0100000, K_I = 7'b0010000;
  localparam logic [6:0] K_S = 7'b0001000, K_B = 7'b0000100, K_U = 7'b0000010;
  localparam logic [6:0] K_J = 7'b0000001, K_0 = 7'b0000000;
  localparam int NV = 23;

  vec_t vt[NV];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    in_instr  = '0;
    in_pc     = '0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic feed(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1'b1;
    in_instr = ins;
    in_pc    = pc;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    vt[0]  = '{32'hFFF00093, K_I,    5'd1,  5'd0, 5'd0, 32'hFFFFFFFF, 4'h0, 1'b1, 1'b0, "ADDI "};
    vt[1]  = '{32'h0020A423, K_S,    5'd0,  5'd1, 5'd2, 32'h00000008, 4'h2, 1'b0, 1'b0, "SW   "};
    vt[2]  = '{32'hFE000EE3, K_B,    5'd0,  5'd0, 5'd0, 32'hFFFFFFFC, 4'h0, 1'b0, 1'b0, "BEQ  "};
    vt[3]  = '{32'h123452B7, K_U,    5'd5,  5'd0, 5'd0, 32'h12345000, 4'h0, 1'b1, 1'b0, "LUI  "};
    vt[4]  = '{32'h00000000, K_0,    5'd0,  5'd0, 5'd0, 32'h00000000, 4'h0, 1'b0, 1'b0, "NOP  "};
    vt[5]  = '{32'h00000013, K_I,    5'd0,  5'd0, 5'd0, 32'h00000000, 4'h0, 1'b0, 1'b0, "ADDI "};
    vt[6]  = '{32'hFFFFFFFF, K_0,    5'd0,  5'd0, 5'd0, 32'h00000000, 4'h0, 1'b0, 1'b1, "ILL  "};
    vt[7]  = '{32'h402081B3, K_R,    5'd3,  5'd1, 5'd2, 32'h00000000, 4'h8, 1'b1, 1'b0, "SUB  "};
    vt[8]  = '{32'h40335293, K_I,    5'd5,  5'd6, 5'd0, 32'h00000403, 4'hD, 1'b1, 1'b0, "SRAI "};
    vt[9]  = '{32'hFFC12383, K_LOAD, 5'd7,  5'd2, 5'd0, 32'hFFFFFFFC, 4'h2, 1'b1, 1'b0, "LW   "};
    vt[10] = '{32'h00003003, K_0,    5'd0,  5'd0, 5'd0, 32'h00000000, 4'h0, 1'b0, 1'b1, "ILL  "};
    vt[11] = '{32'h008000EF, K_J,    5'd1,  5'd0, 5'd0, 32'h00000008, 4'h0, 1'b1, 1'b0, "JAL  "};
    vt[12] = '{32'h00001067, K_0,    5'd0,  5'd0, 5'd0, 32'h00000000, 4'h0, 1'b0, 1'b1, "ILL  "};
    vt[13] = '{32'h00008067, K_I,    5'd0,  5'd1, 5'd0, 32'h00000000, 4'h0, 1'b0, 1'b0, "JALR "};
    vt[14] = '{32'h00003023, K_0,    5'd0,  5'd0, 5'd0, 32'h00000000, 4'h0, 1'b0, 1'b1, "ILL  "};
    vt[15] = '{32'h00002063, K_0,    5'd0,  5'd0, 5'd0, 32'h00000000, 4'h0, 1'b0, 1'b1, "ILL  "};
    vt[16] = '{32'h02001013, K_0,    5'd0,  5'd0, 5'd0, 32'h00000000, 4'h0, 1'b0, 1'b1, "ILL  "};
    vt[17] = '{32'h40001033, K_0,    5'd0,  5'd0, 5'd0, 32'h00000000, 4'h0, 1'b0, 1'b1, "ILL  "};
    vt[18] = '{32'h02208033, K_0,    5'd0,  5'd0, 5'd0, 32'h00000000, 4'h0, 1'b0, 1'b1, "ILL  "};
    vt[19] = '{32'hFFFFF517, K_U,    5'd10, 5'd0, 5'd0, 32'hFFFFF000, 4'h0, 1'b1, 1'b0, "AUIPC"};
    vt[20] = '{32'h0011B113, K_I,    5'd2,  5'd3, 5'd0, 32'h00000001, 4'h3, 1'b1, 1'b0, "SLTIU"};
    vt[21] = '{32'h20005013, K_0,    5'd0,  5'd0, 5'd0, 32'h00000000, 4'h0, 1'b0, 1'b1, "ILL  "};
    vt[22] = '{32'h0062E233, K_R,    5'd4,  5'd5, 5'd6, 32'h00000000, 4'h6, 1'b1, 1'b0, "OR   "};

    // Reset state, observed while reset_n is still low
    reset_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_instr = '0; in_pc = '0;
    step();
    step();
    chk("rst_in_ready", 64'(a_in_ready), 64'd0);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_mnemonic", 64'(a_mn), 64'("NOP  "));
    chk("rst_count", 64'(a_cnt), 64'd0);
    chk("rst_pc", 64'(a_pc), 64'd0);
    reset_n = 1'b1;
    step();
    chk("post_rst_in_ready", 64'(a_in_ready), 64'd1);
    chk("post_rst_in_ready_c", 64'(c_in_ready), 64'd1);

    // Table: back-to-back stream with out_ready=1
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_instr = vt[i].instr;
      in_pc    = 32'h100 + 32'(4 * i);
      step();
      $display("vec %0d instr %h pc %h -> %s cls %b imm %h", i, vt[i].instr, in_pc, a_mn, a_cls, a_imm);
      chk("vec_valid", 64'(a_out_valid), 64'd1);
      chk("vec_pc", 64'(a_pc), 64'(32'h100 + 32'(4 * i)));
      chk("vec_class", 64'(a_cls), 64'(vt[i].cls));
      chk("vec_rd", 64'(a_rd), 64'(vt[i].rd));
      chk("vec_rs1", 64'(a_rs1), 64'(vt[i].rs1));
      chk("vec_rs2", 64'(a_rs2), 64'(vt[i].rs2));
      chk("vec_imm", 64'(a_imm), 64'(vt[i].imm));
      chk("vec_alu_op", 64'(a_alu), 64'(vt[i].alu));
      chk("vec_reg_write", 64'(a_wr), 64'(vt[i].wr));
      chk("vec_illegal", 64'(a_ill), 64'(vt[i].ill));
      chk("vec_mul", 64'(a_mul), 64'd0);
      chk("vec_mnemonic", 64'(a_mn), 64'(vt[i].mn));
      chk("vec_mnemonic_c", 64'(c_mn), 64'(vt[i].mn));
    end
    in_valid = 1'b0;
    step();
    chk("idle_valid", 64'(a_out_valid), 64'd0);

    // Saturating counter (B has CNT_W=2)
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      feed(32'hFFFFFFFF, 32'h200 + 32'(4 * k));
      $display("ill %0d -> a_count %0d b_count %0d %s", k, a_cnt, b_cnt, a_mn);
      chk("cnt_illegal", 64'(a_ill), 64'd1);
      chk("cnt_mnemonic", 64'(a_mn), 64'("ILL  "));
      chk("cnt_a", 64'(a_cnt), 64'(k));
      chk("cnt_b_sat", 64'(b_cnt), 64'((k > 3) ? 3 : k));
    end

    // RV32M decode
    do_reset();
    feed(32'h02208033, 32'h300);
    $display("mul x0,x1,x2 -> a %s b %s", a_mn, b_mn);
    chk("m_off_illegal", 64'(a_ill), 64'd1);
    chk("m_off_mnemonic", 64'(a_mn), 64'("ILL  "));
    chk("m_on_illegal", 64'(b_ill), 64'd0);
    chk("m_on_mul", 64'(b_mul), 64'd1);
    chk("m_on_mnemonic", 64'(b_mn), 64'("MUL  "));
    chk("m_on_reg_write", 64'(b_wr), 64'd0);
    chk("m_on_class", 64'(b_cls), 64'(K_R));
    feed(32'h0220B2B3, 32'h304);
    $display("mulhu x5,x1,x2 -> b %s", b_mn);
    chk("mulhu_mnemonic", 64'(b_mn), 64'("MULHU"));
    chk("mulhu_reg_write", 64'(b_wr), 64'd1);
    chk("mulhu_rd", 64'(b_rd), 64'd5);
    chk("mulhu_alu_op", 64'(b_alu), 64'h3);

    // Backpressure through the skid buffer
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00000013;
    in_pc     = 32'h0;
    step();
    $display("bp c1 out_pc %h in_ready %0d", a_pc, a_in_ready);
    chk("bp1_valid", 64'(a_out_valid), 64'd1);
    chk("bp1_pc", 64'(a_pc), 64'h0);
    chk("bp1_in_ready", 64'(a_in_ready), 64'd1);
    chk("bp1_c_in_ready", 64'(c_in_ready), 64'd0);
    in_pc = 32'h4;
    step();
    $display("bp c2 out_pc %h in_ready %0d", a_pc, a_in_ready);
    chk("bp2_in_ready", 64'(a_in_ready), 64'd0);
    chk("bp2_pc_hold", 64'(a_pc), 64'h0);
    chk("bp2_c_pc_hold", 64'(c_pc), 64'h0);
    in_pc = 32'h8;
    step();
    $display("bp c3 out_pc %h in_ready %0d", a_pc, a_in_ready);
    chk("bp3_in_ready", 64'(a_in_ready), 64'd0);
    chk("bp3_pc_hold", 64'(a_pc), 64'h0);
    chk("bp3_mnemonic_hold", 64'(a_mn), 64'("ADDI "));
    out_ready = 1'b1;
    step();
    $display("bp c4 out_pc %h in_ready %0d", a_pc, a_in_ready);
    chk("bp4_valid", 64'(a_out_valid), 64'd1);
    chk("bp4_pc", 64'(a_pc), 64'h4);
    chk("bp4_in_ready", 64'(a_in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    $display("bp c5 out_pc %h", a_pc);
    chk("bp5_valid", 64'(a_out_valid), 64'd1);
    chk("bp5_pc", 64'(a_pc), 64'h8);
    step();
    chk("bp6_drained", 64'(a_out_valid), 64'd0);

    // Flush with main and skid full, then flush against an acceptance
    do_reset();
    out_ready = 1'b0;
    feed(32'h00000013, 32'h10);
    feed(32'h00000013, 32'h14);
    chk("fl_skid_full", 64'(a_in_ready), 64'd0);
    in_valid = 1'b1;
    in_instr = 32'hFFFFFFFF;
    in_pc    = 32'h18;
    flush    = 1'b1;
    step();
    $display("flush full -> out_valid %0d count %0d", a_out_valid, a_cnt);
    chk("fl_valid", 64'(a_out_valid), 64'd0);
    chk("fl_c_valid", 64'(c_out_valid), 64'd0);
    chk("fl_count", 64'(a_cnt), 64'd0);
    chk("fl_in_ready", 64'(a_in_ready), 64'd1);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    chk("fl_no_delivery", 64'(a_out_valid), 64'd0);
    in_valid = 1'b1;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    $display("flush accept -> out_valid %0d count %0d", a_out_valid, a_cnt);
    chk("fl_acc_valid", 64'(a_out_valid), 64'd0);
    chk("fl_acc_count", 64'(a_cnt), 64'd0);
    step();
    chk("fl_acc_later", 64'(a_out_valid), 64'd0);

    // Reset with both buffers full
    do_reset();
    out_ready = 1'b0;
    feed(32'hFFFFFFFF, 32'h40);
    feed(32'h00000013, 32'h44);
    chk("rs_pre_count", 64'(a_cnt), 64'd1);
    chk("rs_pre_full", 64'(a_in_ready), 64'd0);
    reset_n = 1'b0;
    step();
    $display("reset mid-stall -> out_valid %0d count %0d %s", a_out_valid, a_cnt, a_mn);
    chk("rs_valid", 64'(a_out_valid), 64'd0);
    chk("rs_count", 64'(a_cnt), 64'd0);
    chk("rs_mnemonic", 64'(a_mn), 64'("NOP  "));
    chk("rs_class", 64'(a_cls), 64'd0);
    chk("rs_in_ready", 64'(a_in_ready), 64'd0);
    reset_n = 1'b1;
    step();
    chk("rs_after_in_ready", 64'(a_in_ready), 64'd1);
    chk("rs_after_valid", 64'(a_out_valid), 64'd0);
    out_ready = 1'b1;
    step();
    chk("rs_no_ghost", 64'(a_out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
